// File: rtl/cpu_types_pkg.sv
// Shared types for the operand-forwarding scoreboard.
//   fs_state_e   : stall-watchdog FSM states
//   FwdSel*      : fwd_sel encoding (0 register file, stage index + 1 otherwise)
//   regbits_t    : register index for the 32-entry register file
//   word_t       : 32-bit datapath word
package cpu_types_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StStall
    } fs_state_e;

    localparam int unsigned FwdSelW = 2;

    localparam logic [FwdSelW-1:0] FwdSelRf  = 2'd0;
    localparam logic [FwdSelW-1:0] FwdSelEx  = 2'd1;
    localparam logic [FwdSelW-1:0] FwdSelMem = 2'd2;
    localparam logic [FwdSelW-1:0] FwdSelWb  = 2'd3;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

endpackage

// File: rtl/forwarding_scoreboard_if.sv
// Bundle of every non-clock/reset signal of forwarding_scoreboard.
// Modport fs is the scoreboard's view: decode/pipeline signals in, resolved operands and
// stall status out.
interface forwarding_scoreboard_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned NSRC   = 2,
    parameter int unsigned NSTG   = 3
) ();
    logic [NSRC*REG_W-1:0]  src_reg;
    logic [NSRC*DATA_W-1:0] rf_data;
    logic [NSTG-1:0]        stg_wen;
    logic [NSTG*REG_W-1:0]  stg_dst;
    logic [NSTG*DATA_W-1:0] stg_data;
    logic [NSTG-1:0]        stg_dvalid;
    logic                   issue_valid;
    logic [REG_W-1:0]       issue_dst;
    logic                   issue_long;
    logic                   retire_valid;
    logic [REG_W-1:0]       retire_dst;
    logic                   flush;
    logic [NSRC*DATA_W-1:0] fwd_data;
    logic [NSRC*2-1:0]      fwd_sel;
    logic                   stall;
    logic [15:0]            stall_cnt;
    logic                   deadlock_err;

    modport fs (
        input  src_reg, rf_data, stg_wen, stg_dst, stg_data, stg_dvalid,
        input  issue_valid, issue_dst, issue_long, retire_valid, retire_dst, flush,
        output fwd_data, fwd_sel, stall, stall_cnt, deadlock_err
    );
endinterface

// File: rtl/fwd_select.sv
// Operand resolution for one source register.
//   src_reg_i/rf_data_i       : requested register and its register-file value
//   stg_*_i                   : per-stage write enable, destination, result, result-ready
//   busy_i                    : scoreboard bit for src_reg_i (long-latency op outstanding)
//   fwd_data_o/fwd_sel_o      : resolved operand and its origin
//   hazard_o                  : operand not yet available
module fwd_select
    import cpu_types_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned NSTG   = 3
) (
    input  logic [REG_W-1:0]       src_reg_i,
    input  logic [DATA_W-1:0]      rf_data_i,
    input  logic [NSTG-1:0]        stg_wen_i,
    input  logic [NSTG*REG_W-1:0]  stg_dst_i,
    input  logic [NSTG*DATA_W-1:0] stg_data_i,
    input  logic [NSTG-1:0]        stg_dvalid_i,
    input  logic                   busy_i,
    output logic [DATA_W-1:0]      fwd_data_o,
    output logic [FwdSelW-1:0]     fwd_sel_o,
    output logic                   hazard_o
);

    logic hit;
    int   hit_idx;

    // Scan oldest to youngest so the youngest matching stage is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 0;
        for (int i = int'(NSTG) - 1; i >= 0; i--) begin
            if (stg_wen_i[i] && (stg_dst_i[i*REG_W +: REG_W] == src_reg_i)) begin
                hit     = 1'b1;
                hit_idx = i;
            end
        end
    end

    always_comb begin
        fwd_data_o = rf_data_i;
        fwd_sel_o  = FwdSelRf;
        hazard_o   = 1'b0;
        if (src_reg_i != '0) begin
            if (hit) begin
                // A not-yet-ready youngest producer blocks; older copies are stale.
                if (stg_dvalid_i[hit_idx]) begin
                    fwd_data_o = stg_data_i[hit_idx*DATA_W +: DATA_W];
                    fwd_sel_o  = FwdSelW'(hit_idx + 1);
                end else begin
                    hazard_o = 1'b1;
                end
            end else begin
                hazard_o = busy_i;
            end
        end
    end

endmodule

// File: rtl/forwarding_scoreboard.sv
// Operand forwarding network plus long-latency scoreboard and stall watchdog.
//   CLK/RST            : clock, synchronous active-high reset
//   src_reg/rf_data    : decode source registers and register-file read data
//   stg_*              : per-stage producer info, stage 0 youngest (EX)
//   issue_*/retire_*   : long-latency destination tracking
//   flush              : branch flush, suppresses stall
//   fwd_data/fwd_sel   : resolved operands and their origin per source
//   stall/stall_cnt    : hold decode; saturating total stall cycles
//   deadlock_err       : sticky, set after STALL_MAX consecutive stall cycles
module forwarding_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_W     = 5,
    parameter int unsigned NSRC      = 2,
    parameter int unsigned NSTG      = 3,
    parameter int unsigned STALL_MAX = 255
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NSRC*REG_W-1:0]  src_reg,
    input  logic [NSRC*DATA_W-1:0] rf_data,
    input  logic [NSTG-1:0]        stg_wen,
    input  logic [NSTG*REG_W-1:0]  stg_dst,
    input  logic [NSTG*DATA_W-1:0] stg_data,
    input  logic [NSTG-1:0]        stg_dvalid,
    input  logic                   issue_valid,
    input  logic [REG_W-1:0]       issue_dst,
    input  logic                   issue_long,
    input  logic                   retire_valid,
    input  logic [REG_W-1:0]       retire_dst,
    input  logic                   flush,
    output logic [NSRC*DATA_W-1:0] fwd_data,
    output logic [NSRC*2-1:0]      fwd_sel,
    output logic                   stall,
    output logic [15:0]            stall_cnt,
    output logic                   deadlock_err
);

    localparam int unsigned NReg = 2 ** REG_W;

    logic [NReg-1:0] busy_q, busy_d, busy_eff;
    logic [NSRC-1:0] hazard;
    fs_state_e       state_q, state_d;
    logic [15:0]     run_q, run_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;
    logic            err_q, err_d;

    // While RST is high the scoreboard is treated as already cleared.
    assign busy_eff = RST ? '0 : busy_q;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        fwd_select #(
            .DATA_W (DATA_W),
            .REG_W  (REG_W),
            .NSTG   (NSTG)
        ) u_fwd_select (
            .src_reg_i    (src_reg[g*REG_W +: REG_W]),
            .rf_data_i    (rf_data[g*DATA_W +: DATA_W]),
            .stg_wen_i    (stg_wen),
            .stg_dst_i    (stg_dst),
            .stg_data_i   (stg_data),
            .stg_dvalid_i (stg_dvalid),
            .busy_i       (busy_eff[src_reg[g*REG_W +: REG_W]]),
            .fwd_data_o   (fwd_data[g*DATA_W +: DATA_W]),
            .fwd_sel_o    (fwd_sel[g*2 +: 2]),
            .hazard_o     (hazard[g])
        );
    end

    assign stall = (|hazard) && !flush;

    always_comb begin
        busy_d = busy_q;
        if (retire_valid) begin
            busy_d[retire_dst] = 1'b0;
        end
        // Set after clear so a same-cycle retire/issue of one register leaves it busy.
        if (issue_valid && issue_long && !stall && (issue_dst != '0)) begin
            busy_d[issue_dst] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (stall) state_d = StStall;
            StStall: if (!stall || flush) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        run_d = '0;
        if (state_d == StStall) begin
            run_d = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
        end
        err_d       = err_q | ((state_d == StStall) && (32'(run_d) >= STALL_MAX));
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_q      <= '0;
            state_q     <= StIdle;
            run_q       <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            state_q     <= state_d;
            run_q       <= run_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign deadlock_err = err_q;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Randomised and directed stimulus against a queue-and-array reference model; a monitor
// pops the expected response every cycle and compares it with the DUT outputs.
module tb_forwarding_scoreboard;
    import cpu_types_pkg::*;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned NSRC      = 2;
    localparam int unsigned NSTG      = 3;
    localparam int unsigned STALL_MAX = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    forwarding_scoreboard_if #(
        .DATA_W (DATA_W), .REG_W (REG_W), .NSRC (NSRC), .NSTG (NSTG)
    ) u_if ();

    forwarding_scoreboard #(
        .DATA_W (DATA_W), .REG_W (REG_W), .NSRC (NSRC), .NSTG (NSTG),
        .STALL_MAX (STALL_MAX)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .src_reg      (u_if.src_reg),
        .rf_data      (u_if.rf_data),
        .stg_wen      (u_if.stg_wen),
        .stg_dst      (u_if.stg_dst),
        .stg_data     (u_if.stg_data),
        .stg_dvalid   (u_if.stg_dvalid),
        .issue_valid  (u_if.issue_valid),
        .issue_dst    (u_if.issue_dst),
        .issue_long   (u_if.issue_long),
        .retire_valid (u_if.retire_valid),
        .retire_dst   (u_if.retire_dst),
        .flush        (u_if.flush),
        .fwd_data     (u_if.fwd_data),
        .fwd_sel      (u_if.fwd_sel),
        .stall        (u_if.stall),
        .stall_cnt    (u_if.stall_cnt),
        .deadlock_err (u_if.deadlock_err)
    );

    typedef struct {
        string                  tag;
        logic [NSRC*DATA_W-1:0] data;
        logic [NSRC*2-1:0]      sel;
        logic                   stall;
        logic [15:0]            cnt;
        logic                   err;
    } exp_t;

    exp_t expq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference state: which registers have a long-latency result outstanding, etc.
    bit [31:0] m_busy;
    int        m_cnt;
    int        m_run;
    bit        m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                for (int s = 0; s < NSRC; s++) begin
                    check({e.tag, $sformatf(" fwd_data%0d", s)},
                          64'(u_if.fwd_data[s*DATA_W +: DATA_W]),
                          64'(e.data[s*DATA_W +: DATA_W]));
                    check({e.tag, $sformatf(" fwd_sel%0d", s)},
                          64'(u_if.fwd_sel[s*2 +: 2]), 64'(e.sel[s*2 +: 2]));
                end
                check({e.tag, " stall"}, 64'(u_if.stall), 64'(e.stall));
                check({e.tag, " stall_cnt"}, 64'(u_if.stall_cnt), 64'(e.cnt));
                check({e.tag, " deadlock_err"}, 64'(u_if.deadlock_err), 64'(e.err));
            end
        end
    end

    task automatic idle_inputs();
        u_if.src_reg      = '0;
        u_if.rf_data      = '0;
        u_if.stg_wen      = '0;
        u_if.stg_dst      = '0;
        u_if.stg_data     = '0;
        u_if.stg_dvalid   = '0;
        u_if.issue_valid  = 1'b0;
        u_if.issue_dst    = '0;
        u_if.issue_long   = 1'b0;
        u_if.retire_valid = 1'b0;
        u_if.retire_dst   = '0;
        u_if.flush        = 1'b0;
    endtask

    task automatic set_stage(input int s, input bit wen, input int dst, input word_t d,
                             input bit dv);
        u_if.stg_wen[s]                  = wen;
        u_if.stg_dst[s*REG_W +: REG_W]   = regbits_t'(dst);
        u_if.stg_data[s*DATA_W +: DATA_W] = d;
        u_if.stg_dvalid[s]               = dv;
    endtask

    task automatic set_src(input int s, input int r, input word_t rf);
        u_if.src_reg[s*REG_W +: REG_W]   = regbits_t'(r);
        u_if.rf_data[s*DATA_W +: DATA_W] = rf;
    endtask

    // Predict this cycle's outputs, queue them, then advance the model across the edge.
    task automatic cycle(input string tag);
        exp_t e;
        bit   haz = 1'b0;
        e.tag = tag;
        for (int s = 0; s < NSRC; s++) begin
            int r     = int'(u_if.src_reg[s*REG_W +: REG_W]);
            int found = -1;
            e.data[s*DATA_W +: DATA_W] = u_if.rf_data[s*DATA_W +: DATA_W];
            e.sel[s*2 +: 2]            = 2'd0;
            if (r != 0) begin
                for (int k = 0; k < NSTG; k++) begin
                    if (found < 0 && u_if.stg_wen[k] &&
                        int'(u_if.stg_dst[k*REG_W +: REG_W]) == r) found = k;
                end
                if (found >= 0) begin
                    if (u_if.stg_dvalid[found]) begin
                        e.data[s*DATA_W +: DATA_W] = u_if.stg_data[found*DATA_W +: DATA_W];
                        e.sel[s*2 +: 2]            = 2'(found + 1);
                    end else begin
                        haz = 1'b1;
                    end
                end else if (m_busy[r] && !RST) begin
                    haz = 1'b1;
                end
            end
        end
        e.stall = haz && !u_if.flush;
        e.cnt   = 16'(m_cnt);
        e.err   = m_err;
        expq.push_back(e);
        @(posedge CLK);
        if (RST) begin
            m_busy = '0;
            m_cnt  = 0;
            m_run  = 0;
            m_err  = 1'b0;
        end else begin
            if (u_if.retire_valid) m_busy[u_if.retire_dst] = 1'b0;
            if (u_if.issue_valid && u_if.issue_long && !e.stall && u_if.issue_dst != 0)
                m_busy[u_if.issue_dst] = 1'b1;
            if (e.stall) begin
                if (m_cnt < 65535) m_cnt++;
                m_run++;
                if (m_run >= int'(STALL_MAX)) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1'b1;
        cycle("reset");
        RST = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        idle_inputs();
        RST = 1'b1;
        m_busy = '0; m_cnt = 0; m_run = 0; m_err = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        cycle("post_reset");

        // Youngest producer wins.
        set_stage(0, 1, 5, 32'h11, 1);
        set_stage(1, 1, 5, 32'h22, 1);
        set_src(0, 5, 32'hDEAD);
        cycle("ex_over_mem");
        idle_inputs();

        // Not-ready MEM producer, then ready next cycle.
        do_reset();
        set_stage(1, 1, 8, 32'h88, 0);
        set_stage(2, 1, 8, 32'h99, 1);
        set_src(1, 8, 32'h1234);
        cycle("mem_not_ready");
        u_if.stg_dvalid[1] = 1'b1;
        cycle("mem_ready");
        idle_inputs();

        // Long-latency r3 outstanding for four cycles; retire in the last.
        do_reset();
        u_if.issue_valid = 1'b1; u_if.issue_long = 1'b1; u_if.issue_dst = 5'd3;
        cycle("issue_r3");
        idle_inputs();
        set_src(0, 3, 32'h33);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin u_if.retire_valid = 1'b1; u_if.retire_dst = 5'd3; end
            cycle($sformatf("busy_r3_%0d", i));
        end
        u_if.retire_valid = 1'b0;
        cycle("r3_retired");
        cycle("err_sticky");

        // Same-cycle retire and issue of r7 leaves it busy; flush and reset during stall.
        do_reset();
        u_if.issue_valid = 1'b1; u_if.issue_long = 1'b1; u_if.issue_dst = 5'd7;
        u_if.retire_valid = 1'b1; u_if.retire_dst = 5'd7;
        cycle("retire_issue_r7");
        idle_inputs();
        set_src(0, 7, 32'h77);
        cycle("r7_busy");
        u_if.flush = 1'b1;
        cycle("flush_in_stall");
        u_if.flush = 1'b0;
        cycle("r7_busy_after_flush");
        RST = 1'b1;
        cycle("reset_in_stall");
        RST = 1'b0;
        cycle("r7_cleared");

        // Register 0 never forwards.
        set_src(0, 0, 32'hABCD);
        set_stage(0, 1, 0, 32'hFFFF, 1);
        cycle("r0_no_fwd");
        idle_inputs();

        // Persistent hazard drives the watchdog.
        do_reset();
        set_stage(2, 1, 9, 32'h0, 0);
        set_src(1, 9, 32'h5);
        for (int i = 0; i < 6; i++) cycle($sformatf("deadlock_%0d", i));
        idle_inputs();
        cycle("deadlock_sticky");

        // Random traffic.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int s = 0; s < NSRC; s++) set_src(s, int'($urandom_range(0, 7)), $urandom);
            for (int k = 0; k < NSTG; k++)
                set_stage(k, bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
                          $urandom_range(0, 3) != 0);
            u_if.issue_valid  = $urandom_range(0, 1) == 1;
            u_if.issue_long   = $urandom_range(0, 1) == 1;
            u_if.issue_dst    = regbits_t'($urandom_range(0, 7));
            u_if.retire_valid = $urandom_range(0, 2) == 0;
            u_if.retire_dst   = regbits_t'($urandom_range(0, 7));
            u_if.flush        = $urandom_range(0, 7) == 0;
            RST               = $urandom_range(0, 63) == 0;
            cycle($sformatf("rand_%0d", n));
        end
        RST = 1'b0;
        idle_inputs();

        repeat (3) @(posedge CLK);
        check("queue_drained", 64'(expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
